arm_decode_unit: RTL and testbench
==================================

# arm_decode_unit

Instruction-decode stage of the 5-stage ARM-subset pipeline, between the IF/ID and ID/EXE registers. It evaluates the condition field against the status flags and decodes control signals, gating them with hazard and condition-fail. It extracts operand fields and reads two source registers from a 16×32 register file, which the write-back stage writes.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Instraction  in  32  instruction from IF/ID register
- Resault_WB  in  32  write-back data
- writeBackEn  in  1  write-back enable
- Dest_wb  in  4  write-back register index
- hazard  in  1  hazard-unit stall; forces controls to 0
- SR  in  4  status flags {N,Z,C,V} (bit3=N … bit0=V)
- EXE_CMD  out  4  ALU command
- MEM_R_EN, MEM_W_EN, WB_EN, B, S  out  1 each  load, store, reg write-back, branch, update-flags
- Val_Rn, Val_Rm  out  32  register read data (port 1: Instraction[19:16]; port 2: src2)
- imm  out  1  Instraction[25]
- Shift_operand  out  12  Instraction[11:0]
- Signed_imm_24  out  24  Instraction[23:0]
- Dest  out  4  Instraction[15:12]
- src1  out  4  Instraction[19:16]
- src2  out  4  MEM_W_EN_raw ? Instraction[15:12] : Instraction[3:0]
- Two_src  out  1  ~imm | MEM_W_EN_raw
- MOV_MVN  out  1  Instraction[24:21] is 1101 or 1111
- NOP  out  1  Instraction == 32'h0

## Operation
- Condition check on Instraction[31:28]: EQ 0000 Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1110 →1; 1111 →0 (invalid).
- Control decode from mode=[27:26], op=[24:21], Sbit=[20]; raw word {EXE_CMD,MEM_R_EN,MEM_W_EN,WB_EN,B,S}.
- Mode 00 (WB_EN=1, S=Sbit): MOV 1101→0001; MVN 1111→1001; ADD 0100→0010; ADC 0101→0011; SUB 0010→0100; SBC 0110→0101; AND 0000→0110; ORR 1100→0111; EOR 0001→1000.
- Mode 00, CMP 1010→0100 and TST 1000→0110: WB_EN=0, S=Sbit.
- Any other mode-00 op: all raw controls 0.
- Mode 01, Sbit=1 (LDR): EXE_CMD=0010, MEM_R_EN=1, WB_EN=1, S=0.
- Mode 01, Sbit=0 (STR): EXE_CMD=0010, MEM_W_EN=1, WB_EN=0, S=0.
- Mode 10: B=1, EXE_CMD=0000, rest 0. Mode 11: all 0.
- NOP=1 forces all raw controls to 0.
- Output controls = 0 when condition fails or hazard=1, else raw controls.
- src2 and Two_src use the raw (ungated) MEM_W_EN, so store operands are read even when gated.
- Register file: 16×32; two asynchronous read ports.
- Write on rising clk when writeBackEn=1: reg[Dest_wb] ← Resault_WB.
- Write-through bypass: a read whose index equals Dest_wb while writeBackEn=1 returns Resault_WB in the same cycle.
- R15 is an ordinary register here.

## Timing
- Everything except register contents is purely combinational from inputs; zero latency.
- Reset: on rising clk with rst=1, reg[i] ← i (R0=0 … R15=15). Reset has priority over a simultaneous write.
- Written value is visible on the read port combinationally via bypass in the write cycle, and from the array from the next cycle on.
- Output values under reset follow the combinational rules, with Val_Rn/Val_Rm reflecting post-reset contents.

## Test plan
- rst one cycle, then src1=2 and src2=Rm=3 -> Val_Rn=2, Val_Rm=3.
- Instraction=0xE2821005 (ADD R1,R2,#5), SR=0 -> EXE_CMD=0010, WB_EN=1, S=0, imm=1, src1=2, Dest=1, Two_src=0.
- Instraction=0xE5843008 (STR R3,[R4,#8]) -> MEM_W_EN=1, WB_EN=0, EXE_CMD=0010, src2=3, Two_src=1; repeat with hazard=1 -> all controls 0, src2 still 3.
- Instraction=0x02821005 (ADDEQ), SR=0000 -> controls 0; SR=0100 -> EXE_CMD=0010, WB_EN=1.
- writeBackEn=1, Dest_wb=5, Resault_WB=0xDEADBEEF, Instraction[19:16]=5 -> Val_Rn=0xDEADBEEF in the same cycle and after the clock; then rst -> Val_Rn=5.
- Instraction=0x00000000 -> NOP=1, all controls 0. Instraction=0xEA000003 -> B=1, WB_EN=0, Signed_imm_24=0x000003.

Source files
------------

// File: rtl/arm_decode_unit.sv
// ARM-subset instruction decode stage: condition check, control decode with
// hazard/condition gating, operand field extraction and a 16x32 register file.
module arm_decode_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instraction,
  input  logic [31:0] Resault_WB,
  input  logic        writeBackEn,
  input  logic [3:0]  Dest_wb,
  input  logic        hazard,
  input  logic [3:0]  SR,
  output logic [3:0]  EXE_CMD,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        WB_EN,
  output logic        B,
  output logic        S,
  output logic [31:0] Val_Rn,
  output logic [31:0] Val_Rm,
  output logic        imm,
  output logic [11:0] Shift_operand,
  output logic [23:0] Signed_imm_24,
  output logic [3:0]  Dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        Two_src,
  output logic        MOV_MVN,
  output logic        NOP
);

  logic [31:0] regs [16];
  logic [1:0]  mode;
  logic [3:0]  op;
  logic        sbit;
  logic        cond_ok;
  logic        mem_w_raw;
  logic [8:0]  raw_ctrl;   // {EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B, S}
  logic [8:0]  ctrl;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
    logic n, z, c, v;
    {n, z, c, v} = sr;
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Write-through: a same-cycle write to the read index wins over the array.
  function automatic logic [31:0] rf_read(input logic [3:0] idx, input logic wen,
                                          input logic [3:0] widx, input logic [31:0] wdata,
                                          input logic [31:0] stored);
    rf_read = (wen && idx == widx) ? wdata : stored;
  endfunction

  assign mode          = Instraction[27:26];
  assign op            = Instraction[24:21];
  assign sbit          = Instraction[20];
  assign imm           = Instraction[25];
  assign Shift_operand = Instraction[11:0];
  assign Signed_imm_24 = Instraction[23:0];
  assign Dest          = Instraction[15:12];
  assign src1          = Instraction[19:16];
  assign NOP           = (Instraction == 32'h0);
  assign MOV_MVN       = (op == 4'b1101) || (op == 4'b1111);
  assign cond_ok       = cond_pass(Instraction[31:28], SR);

  always_comb begin
    raw_ctrl = '0;
    case (mode)
      2'b00: begin
        case (op)
          4'b1101: raw_ctrl = {4'b0001, 3'b001, 1'b0, sbit};
          4'b1111: raw_ctrl = {4'b1001, 3'b001, 1'b0, sbit};
          4'b0100: raw_ctrl = {4'b0010, 3'b001, 1'b0, sbit};
          4'b0101: raw_ctrl = {4'b0011, 3'b001, 1'b0, sbit};
          4'b0010: raw_ctrl = {4'b0100, 3'b001, 1'b0, sbit};
          4'b0110: raw_ctrl = {4'b0101, 3'b001, 1'b0, sbit};
          4'b0000: raw_ctrl = {4'b0110, 3'b001, 1'b0, sbit};
          4'b1100: raw_ctrl = {4'b0111, 3'b001, 1'b0, sbit};
          4'b0001: raw_ctrl = {4'b1000, 3'b001, 1'b0, sbit};
          4'b1010: raw_ctrl = {4'b0100, 3'b000, 1'b0, sbit};
          4'b1000: raw_ctrl = {4'b0110, 3'b000, 1'b0, sbit};
          default: raw_ctrl = '0;
        endcase
      end
      2'b01: begin
        if (sbit) raw_ctrl = {4'b0010, 3'b101, 1'b0, 1'b0};
        else      raw_ctrl = {4'b0010, 3'b010, 1'b0, 1'b0};
      end
      2'b10:   raw_ctrl = {4'b0000, 3'b000, 1'b1, 1'b0};
      default: raw_ctrl = '0;
    endcase
    if (NOP) raw_ctrl = '0;
  end

  // Operand selection uses the ungated store flag so a stalled store still reads Rd.
  assign mem_w_raw = raw_ctrl[3];
  assign src2      = mem_w_raw ? Instraction[15:12] : Instraction[3:0];
  assign Two_src   = ~imm | mem_w_raw;

  assign ctrl = (cond_ok && !hazard) ? raw_ctrl : '0;
  assign {EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B, S} = ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'(i);
    end else if (writeBackEn) begin
      regs[Dest_wb] <= Resault_WB;
    end
  end

  assign Val_Rn = rf_read(src1, writeBackEn, Dest_wb, Resault_WB, regs[src1]);
  assign Val_Rm = rf_read(src2, writeBackEn, Dest_wb, Resault_WB, regs[src2]);

endmodule

// File: tb/tb_arm_decode_unit.sv
// Scoreboard bench for arm_decode_unit: stimulus pushes hand-computed
// expectations, a monitor compares them mid-cycle against the DUT outputs.
module tb_arm_decode_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instraction, Resault_WB;
  logic        writeBackEn, hazard;
  logic [3:0]  Dest_wb, SR;
  logic [3:0]  EXE_CMD;
  logic        MEM_R_EN, MEM_W_EN, WB_EN, B, S;
  logic [31:0] Val_Rn, Val_Rm;
  logic        imm, Two_src, MOV_MVN, NOP;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [3:0]  Dest, src1, src2;

  typedef struct {
    string       nm;
    logic [8:0]  ctrl;
    logic [31:0] rn, rm;
    logic [3:0]  s1, s2, d;
    logic        im, two, mm, np;
    logic [11:0] sh;
    logic [23:0] si;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  bit done = 0;

  arm_decode_unit dut (
    .clk(clk), .rst(rst), .Instraction(Instraction), .Resault_WB(Resault_WB),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .hazard(hazard), .SR(SR),
    .EXE_CMD(EXE_CMD), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
    .B(B), .S(S), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .Dest(Dest),
    .src1(src1), .src2(src2), .Two_src(Two_src), .MOV_MVN(MOV_MVN), .NOP(NOP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h expected=0x%0h", nm, fld, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [3:0] sr, input logic hz,
                       input logic wbe, input logic [3:0] dwb, input logic [31:0] res);
    @(negedge clk);
    Instraction = ins; SR = sr; hazard = hz;
    writeBackEn = wbe; Dest_wb = dwb; Resault_WB = res;
  endtask

  task automatic expect_out(input string nm, input logic [8:0] ctrl, input logic [31:0] rn,
                            input logic [31:0] rm, input logic [3:0] s1, input logic [3:0] s2,
                            input logic [3:0] d, input logic im, input logic two,
                            input logic [11:0] sh, input logic [23:0] si,
                            input logic mm, input logic np);
    exp_t e;
    e.nm = nm; e.ctrl = ctrl; e.rn = rn; e.rm = rm; e.s1 = s1; e.s2 = s2; e.d = d;
    e.im = im; e.two = two; e.sh = sh; e.si = si; e.mm = mm; e.np = np;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so compare 1 time unit after each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "ctrl", {23'd0, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B, S}, {23'd0, e.ctrl});
        chk(e.nm, "Val_Rn", Val_Rn, e.rn);
        chk(e.nm, "Val_Rm", Val_Rm, e.rm);
        chk(e.nm, "src1", {28'd0, src1}, {28'd0, e.s1});
        chk(e.nm, "src2", {28'd0, src2}, {28'd0, e.s2});
        chk(e.nm, "Dest", {28'd0, Dest}, {28'd0, e.d});
        chk(e.nm, "imm", {31'd0, imm}, {31'd0, e.im});
        chk(e.nm, "Two_src", {31'd0, Two_src}, {31'd0, e.two});
        chk(e.nm, "Shift_operand", {20'd0, Shift_operand}, {20'd0, e.sh});
        chk(e.nm, "Signed_imm_24", {8'd0, Signed_imm_24}, {8'd0, e.si});
        chk(e.nm, "MOV_MVN", {31'd0, MOV_MVN}, {31'd0, e.mm});
        chk(e.nm, "NOP", {31'd0, NOP}, {31'd0, e.np});
      end
    end
  end

  initial begin
    rst = 1'b1; Instraction = '0; Resault_WB = '0; writeBackEn = 1'b0;
    Dest_wb = '0; hazard = 1'b0; SR = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // ctrl = {EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B, S}; registers hold Ri = i after reset
    drive(32'hE0823003, 4'b0000, 0, 0, 0, 0);
    expect_out("reset_add_reg", 9'h044, 2, 3, 2, 3, 3, 0, 1, 12'h003, 24'h823003, 0, 0);
    drive(32'hE2821005, 4'b0000, 0, 0, 0, 0);
    expect_out("add_imm", 9'h044, 2, 5, 2, 5, 1, 1, 0, 12'h005, 24'h821005, 0, 0);
    drive(32'hE5843008, 4'b0000, 0, 0, 0, 0);
    expect_out("str", 9'h048, 4, 3, 4, 3, 3, 0, 1, 12'h008, 24'h843008, 0, 0);
    drive(32'hE5843008, 4'b0000, 1, 0, 0, 0);
    expect_out("str_hazard", 9'h000, 4, 3, 4, 3, 3, 0, 1, 12'h008, 24'h843008, 0, 0);
    drive(32'h02821005, 4'b0000, 0, 0, 0, 0);
    expect_out("addeq_fail", 9'h000, 2, 5, 2, 5, 1, 1, 0, 12'h005, 24'h821005, 0, 0);
    drive(32'h02821005, 4'b0100, 0, 0, 0, 0);
    expect_out("addeq_pass", 9'h044, 2, 5, 2, 5, 1, 1, 0, 12'h005, 24'h821005, 0, 0);
    drive(32'hE3A01007, 4'b0000, 0, 0, 0, 0);
    expect_out("mov_imm", 9'h024, 0, 7, 0, 7, 1, 1, 0, 12'h007, 24'hA01007, 1, 0);
    drive(32'hE5942000, 4'b0000, 0, 0, 0, 0);
    expect_out("ldr", 9'h054, 4, 0, 4, 0, 2, 0, 1, 12'h000, 24'h942000, 0, 0);
    drive(32'hE1520003, 4'b0000, 0, 0, 0, 0);
    expect_out("cmp_s", 9'h081, 2, 3, 2, 3, 0, 0, 1, 12'h003, 24'h520003, 0, 0);
    drive(32'hC2821005, 4'b0000, 0, 0, 0, 0);
    expect_out("gt_pass", 9'h044, 2, 5, 2, 5, 1, 1, 0, 12'h005, 24'h821005, 0, 0);
    drive(32'hC2821005, 4'b1000, 0, 0, 0, 0);
    expect_out("gt_fail", 9'h000, 2, 5, 2, 5, 1, 1, 0, 12'h005, 24'h821005, 0, 0);
    drive(32'hF2821005, 4'b0100, 0, 0, 0, 0);
    expect_out("cond_invalid", 9'h000, 2, 5, 2, 5, 1, 1, 0, 12'h005, 24'h821005, 0, 0);

    // Write-back into R5: bypass in the write cycle, then stored, then cleared by reset
    drive(32'hE2851000, 4'b0000, 0, 1, 5, 32'hDEADBEEF);
    expect_out("wb_bypass", 9'h044, 32'hDEADBEEF, 0, 5, 0, 1, 1, 0, 12'h000, 24'h851000, 0, 0);
    drive(32'hE2851000, 4'b0000, 0, 0, 0, 0);
    expect_out("wb_stored", 9'h044, 32'hDEADBEEF, 0, 5, 0, 1, 1, 0, 12'h000, 24'h851000, 0, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    drive(32'hE2851000, 4'b0000, 0, 0, 0, 0);
    expect_out("wb_after_rst", 9'h044, 5, 0, 5, 0, 1, 1, 0, 12'h000, 24'h851000, 0, 0);

    drive(32'h00000000, 4'b0100, 0, 0, 0, 0);
    expect_out("nop", 9'h000, 0, 0, 0, 0, 0, 0, 1, 12'h000, 24'h000000, 0, 1);
    drive(32'hEA000003, 4'b0000, 0, 0, 0, 0);
    expect_out("branch", 9'h002, 0, 3, 0, 3, 0, 1, 0, 12'h003, 24'h000003, 0, 0);

    @(negedge clk); @(negedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
